// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor. Operands are captured on an in_valid/in_ready
//   handshake, then processed LSB first, one bit per clock, through a full
//   subtractor built from two half-subtractor stages. The WIDTH-bit difference
//   and final borrow are presented on an out_valid/out_ready handshake and held
//   until the next operation starts shifting.
//
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous active-high reset
//     in_valid   operands a/b valid          in_ready   block can accept operands
//     a, b       minuend / subtrahend (unsigned, WIDTH bits)
//     out_valid  result valid                out_ready  consumer accepts result
//     diff       a - b modulo 2^WIDTH        borrow_out 1 when a < b (unsigned)
//     overflow   two's-complement overflow of a - b
//
//   Optional feature macro: SUB_OVERFLOW_EN
//     defined   : overflow computed from operand MSBs captured at load
//     undefined : overflow tied to 0, MSB capture registers not built
//
//   Parameter WIDTH: operand/result width, legal range 2..32.

module serial_subtractor_halfsub (
   input  logic x_i,
   input  logic y_i,
   output logic d_o,
   output logic b_o
);
   assign d_o = x_i ^ y_i;
   assign b_o = ~x_i & y_i;
endmodule

module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_sh_q;
   logic [WIDTH-1:0] b_sh_q;
   logic [WIDTH-1:0] diff_q;
   logic [CW-1:0]    cnt_q;
   logic             br_q;
   logic             borrow_q;
   logic             out_valid_q;

   // Full subtractor: first stage a-b, second stage subtracts the stored borrow.
   logic hs1_d, hs1_b, hs2_b;
   logic bit_d, bo_d;

   serial_subtractor_halfsub u_hs1 (
      .x_i (a_sh_q[0]),
      .y_i (b_sh_q[0]),
      .d_o (hs1_d),
      .b_o (hs1_b)
   );

   serial_subtractor_halfsub u_hs2 (
      .x_i (hs1_d),
      .y_i (br_q),
      .d_o (bit_d),
      .b_o (hs2_b)
   );

   assign bo_d = hs1_b | hs2_b;

`ifdef SUB_OVERFLOW_EN
   logic a_msb_q, b_msb_q, ovf_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         diff_q      <= '0;
         cnt_q       <= '0;
         br_q        <= 1'b0;
         borrow_q    <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
         a_msb_q     <= 1'b0;
         b_msb_q     <= 1'b0;
         ovf_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  a_sh_q  <= a;
                  b_sh_q  <= b;
                  br_q    <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= S_SHIFT;
`ifdef SUB_OVERFLOW_EN
                  a_msb_q <= a[WIDTH-1];
                  b_msb_q <= b[WIDTH-1];
`endif
               end
            end
            S_SHIFT: begin
               // WIDTH shift edges, then one further edge that publishes the
               // result; borrow_out is copied from br here so it only moves
               // while shifting, not when br is cleared at load.
               if (cnt_q == CW'(WIDTH)) begin
                  state_q     <= S_DONE;
                  out_valid_q <= 1'b1;
                  borrow_q    <= br_q;
`ifdef SUB_OVERFLOW_EN
                  ovf_q       <= (a_msb_q != b_msb_q) && (diff_q[WIDTH-1] != a_msb_q);
`endif
               end else begin
                  diff_q <= {bit_d, diff_q[WIDTH-1:1]};
                  a_sh_q <= a_sh_q >> 1;
                  b_sh_q <= b_sh_q >> 1;
                  br_q   <= bo_d;
                  cnt_q  <= cnt_q + CW'(1);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Gated by rst so the block never advertises readiness while held in reset.
   assign in_ready   = (state_q == S_IDLE) && !rst;
   assign out_valid  = out_valid_q;
   assign diff       = diff_q;
   assign borrow_out = borrow_q;
`ifdef SUB_OVERFLOW_EN
   assign overflow   = ovf_q;
`else
   assign overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, out_valid, out_ready, borrow_out, overflow;
   logic [7:0] a, b, diff;

   logic       in_valid2, in_ready2, out_valid2, out_ready2, borrow_out2, overflow2;
   logic [1:0] a2, b2, diff2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .diff       (diff),
      .borrow_out (borrow_out),
      .overflow   (overflow)
   );

   serial_subtractor #(.WIDTH(2)) dut2 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid2),
      .in_ready   (in_ready2),
      .a          (a2),
      .b          (b2),
      .out_valid  (out_valid2),
      .out_ready  (out_ready2),
      .diff       (diff2),
      .borrow_out (borrow_out2),
      .overflow   (overflow2)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] d;
      logic       bo;
      logic       ov;   // expected overflow when the feature is built
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic exp_ovf(input logic ov);
`ifdef SUB_OVERFLOW_EN
      return ov;
`else
      return 1'b0 & ov;
`endif
   endfunction

   // ---- WIDTH=8 helpers ----
   task automatic issue8(input logic [7:0] ta, input logic [7:0] tb_v);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", in_ready, 1);
      a = ta; b = tb_v; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0; a = '0; b = '0;
   endtask

   task automatic wait8(output int lat);
      lat = 0;
      while (lat < 50) begin
         @(posedge clk);
         lat++;
         #1;
         if (lat == 3) check("in_ready_busy", in_ready, 0);
         if (out_valid) break;
      end
      check("out_valid_seen", out_valid, 1);
   endtask

   task automatic release8();
      @(negedge clk) out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check("out_valid_drop", out_valid, 0);
   endtask

   // ---- WIDTH=2 helpers ----
   task automatic op2(input logic [1:0] ta, input logic [1:0] tb_v);
      int lat;
      @(negedge clk);
      check("w2_in_ready", in_ready2, 1);
      a2 = ta; b2 = tb_v; in_valid2 = 1'b1;
      @(posedge clk);
      #1 in_valid2 = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         lat++;
         #1;
         if (out_valid2) break;
      end
      check("w2_latency", lat, 3);
      check("w2_diff", diff2, 2'(ta - tb_v));
      check("w2_borrow", borrow_out2, (ta < tb_v));
      @(negedge clk) out_ready2 = 1'b1;
      @(posedge clk);
      #1 out_ready2 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      vecs[0] = '{8'd5,   8'd3,   8'h02, 1'b0, 1'b0};
      vecs[1] = '{8'd3,   8'd5,   8'hFE, 1'b1, 1'b0};
      vecs[2] = '{8'h00,  8'h01,  8'hFF, 1'b1, 1'b0};
      vecs[3] = '{8'hA5,  8'hA5,  8'h00, 1'b0, 1'b0};
      vecs[4] = '{8'h80,  8'h01,  8'h7F, 1'b0, 1'b1};
      vecs[5] = '{8'h10,  8'h01,  8'h0F, 1'b0, 1'b0};
      vecs[6] = '{8'd9,   8'd4,   8'h05, 1'b0, 1'b0};
      vecs[7] = '{8'h7F,  8'hFF,  8'h80, 1'b1, 1'b1};
      vecs[8] = '{8'hFF,  8'h00,  8'hFF, 1'b0, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0;
      #3;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_diff", diff, 0);
      check("rst_borrow", borrow_out, 0);
      check("rst_overflow", overflow, 0);
      @(negedge clk);
      @(negedge clk) rst = 1'b0;
      #1 check("idle_in_ready", in_ready, 1);

      // Table-driven vectors
      for (int i = 0; i < 9; i++) begin
         issue8(vecs[i].a, vecs[i].b);
         wait8(lat);
         check("latency", lat, 9);
         @(negedge clk);
         check("diff", diff, vecs[i].d);
         check("borrow", borrow_out, vecs[i].bo);
         check("overflow", overflow, exp_ovf(vecs[i].ov));
         release8();
         check("diff_hold", diff, vecs[i].d);
      end

      // Backpressure: 200-100 held 20 clocks, new operands offered meanwhile
      issue8(8'd200, 8'd100);
      wait8(lat);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         in_valid = 1'b1; a = 8'd1; b = 8'd2;
         check("bp_valid", out_valid, 1);
         check("bp_diff", diff, 8'h64);
         check("bp_borrow", borrow_out, 0);
         check("bp_ovf", overflow, exp_ovf(1'b1));
         check("bp_in_ready", in_ready, 0);
      end
      @(negedge clk) out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check("bp_valid_drop", out_valid, 0);
      check("bp_idle_ready", in_ready, 1);
      check("bp_not_taken", diff, 8'h64);
      @(posedge clk);
      #1 in_valid = 1'b0; a = '0; b = '0;
      check("bp_accepted", in_ready, 0);
      wait8(lat);
      check("bp_next_lat", lat, 9);
      @(negedge clk);
      check("bp_next_diff", diff, 8'hFF);
      check("bp_next_borrow", borrow_out, 1);
      release8();

      // Reset during the 4th shift cycle
      issue8(8'hF0, 8'h0F);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_diff", diff, 0);
      check("mid_rst_borrow", borrow_out, 0);
      check("mid_rst_ovf", overflow, 0);
      check("mid_rst_ready", in_ready, 0);
      @(negedge clk) rst = 1'b0;
      #1 check("post_rst_idle", in_ready, 1);
      repeat (12) @(posedge clk);
      #1 check("post_rst_no_out", out_valid, 0);
      issue8(8'd9, 8'd4);
      wait8(lat);
      check("post_rst_lat", lat, 9);
      @(negedge clk);
      check("post_rst_diff", diff, 8'h05);
      check("post_rst_borrow", borrow_out, 0);
      release8();

      // WIDTH=2 exhaustive
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            op2(2'(i), 2'(j));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
